uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   Serialises one byte per frame onto a UART line: start bit (0), eight data
//   bits LSB first, optional parity bit, then one or two stop bits (1).
//   Bit timing comes from baud_clk, a divided clock that is sampled as a plain
//   signal in the clk_in domain; every rising edge of baud_clk is one bit step.
//
// Parameters
//   PARITY_EN   1 inserts a parity bit after data bit 7
//   PARITY_ODD  0 even parity, 1 odd parity (ignored when PARITY_EN = 0)
//   STOP_BITS   number of stop bits, 1 or 2
//
// Ports
//   clk_in    in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   baud_clk  in   divided bit clock (resets high, like its divider)
//   tx_data   in   [7:0] byte to send
//   tx_valid  in   tx_data is valid
//   tx_ready  out  block is idle and can accept a byte
//   tx        out  registered serial line, idle high
//   tx_done   out  one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       baud_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    // stop_cnt value on the final stop bit (0 for one stop bit, 1 for two).
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    logic [2:0] state_q,    state_d;
    logic       tx_q,       tx_d;
    logic       tx_done_q,  tx_done_d;
    logic       baud_q,     baud_d;
    logic [7:0] shreg_q,    shreg_d;
    logic [2:0] bit_idx_q,  bit_idx_d;
    logic       stop_cnt_q, stop_cnt_d;

    logic tick;
    logic parity_bit;

    // One tick per rising edge of baud_clk.
    assign tick = baud_clk & ~baud_q;

    // The shift register rotates rather than shifts, so all eight latched bits
    // are still present when parity is needed; XOR is rotation-invariant.
    assign parity_bit = (^shreg_q) ^ PARITY_ODD;

    assign tx_ready = (state_q == S_IDLE);
    assign tx       = tx_q;
    assign tx_done  = tx_done_q;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned; that is what keeps this block free of inferred latches.
        state_d    = state_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
        baud_d     = baud_clk;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;

        case (state_q)
            S_IDLE: begin
                // A tick in the accept cycle is deliberately ignored: ARMED
                // waits for the next one, so the start bit is a full period.
                if (tx_valid) begin
                    shreg_d = tx_data;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (tick) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    tx_d      = shreg_q[0];
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx_q != 3'd7) begin
                        shreg_d   = {shreg_q[0], shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (PARITY_EN) begin
                        state_d = S_PARITY;
                        tx_d    = parity_bit;
                    end else begin
                        state_d    = S_STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d   = S_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            // Matches the divider's reset level: no spurious tick at release.
            baud_q     <= 1'b1;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            baud_q     <= baud_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Four serializer instances share one stimulus stream:
//     0 base   : no parity, one stop bit
//     1 even   : even parity, one stop bit
//     2 odd    : odd parity, one stop bit
//     3 stop2  : no parity, two stop bits
//   baud_clk is produced by a divide-by-8 model (div = 3) that resets high.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       baud_clk;
    logic       baud_prev;
    logic [1:0] div_cnt;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] tx_v, ready_v, done_v;

    int n_checks = 0;
    int n_fail   = 0;

    string inst_name [4] = '{"base", "even", "odd", "stop2"};

    typedef struct {
        logic [7:0] data;
        bit         align;    // present the byte in a tick cycle
        bit         busy;     // keep tx_valid high with other data mid-frame
        logic       par_even; // hand-computed even parity bit
        logic       par_odd;  // hand-computed odd parity bit
    } vec_t;

    vec_t vecs [5];

    always #5 clk_in = ~clk_in;

    // clk_div model, div = 3: toggles every 4 cycles, resets high.
    // baud_prev is the value the DUT holds as its previous baud_clk sample.
    always @(posedge clk_in) begin
        if (rst) begin
            div_cnt   <= 2'd0;
            baud_clk  <= 1'b1;
            baud_prev <= 1'b1;
        end else begin
            baud_prev <= baud_clk;
            div_cnt   <= div_cnt + 2'd1;
            if (div_cnt == 2'd3) baud_clk <= ~baud_clk;
        end
    end

    uart_tx_serializer u_base (
        .clk_in(clk_in), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_done(done_v[0])
    );
    uart_tx_serializer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .clk_in(clk_in), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_done(done_v[1])
    );
    uart_tx_serializer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .clk_in(clk_in), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_done(done_v[2])
    );
    uart_tx_serializer #(.STOP_BITS(2)) u_stop2 (
        .clk_in(clk_in), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(ready_v[3]), .tx(tx_v[3]), .tx_done(done_v[3])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // True at a negedge when the coming rising edge is a tick for the DUT.
    function automatic bit tick_next();
        return baud_clk && !baud_prev;
    endfunction

    // Advance past the next tick edge; ends at the negedge after it.
    task automatic wait_tick();
        int g = 0;
        while (!tick_next() && g < 40) begin
            @(negedge clk_in);
            g++;
        end
        check("tick within budget", (g < 40) ? 1 : 0, 1);
        @(negedge clk_in);
    endtask

    task automatic wait_all_ready();
        int g = 0;
        while (ready_v !== 4'hF && g < 300) begin
            @(negedge clk_in);
            g++;
        end
        check("all ready within budget", ready_v, 4'hF);
    endtask

    // Expected outputs of every instance in bit period p (-1 = armed,
    // 0 = start, 1..8 = data, 9.. = parity/stop/idle), cycle cyc within it.
    task automatic check_cycle(input logic [7:0] d, input int p, input int cyc,
                               input logic pe, input logic po);
        for (int i = 0; i < 4; i++) begin
            logic exp_tx;
            int   last;
            last = (i == 0) ? 10 : 11;
            if (p < 0)                   exp_tx = 1'b1;
            else if (p == 0)             exp_tx = 1'b0;
            else if (p <= 8)             exp_tx = d[p-1];
            else if (p == 9 && i == 1)   exp_tx = pe;
            else if (p == 9 && i == 2)   exp_tx = po;
            else                         exp_tx = 1'b1;
            check($sformatf("%s tx byte %02h period %0d", inst_name[i], d, p),
                  tx_v[i], exp_tx);
            check($sformatf("%s tx_done byte %02h period %0d cyc %0d", inst_name[i], d, p, cyc),
                  done_v[i], (p == last && cyc == 0) ? 1 : 0);
            check($sformatf("%s tx_ready byte %02h period %0d", inst_name[i], d, p),
                  ready_v[i], (p >= last) ? 1 : 0);
        end
    endtask

    // Send one byte to all instances and check every cycle of the frame.
    task automatic run_frame(input vec_t v);
        int p   = -1;
        int cyc = 0;
        wait_all_ready();
        if (v.align) begin
            int g = 0;
            while (!tick_next() && g < 40) begin
                @(negedge clk_in);
                g++;
            end
            check("aligned tick found", (g < 40) ? 1 : 0, 1);
        end
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(negedge clk_in);
        if (v.busy) tx_data = ~v.data;
        else        tx_valid = 1'b0;
        for (int n = 0; n < 200 && p < 12; n++) begin
            // Drop the junk request before the shortest frame goes idle.
            if (p == 9) tx_valid = 1'b0;
            check_cycle(v.data, p, cyc, v.par_even, v.par_odd);
            if (tick_next()) begin
                if (p >= 0 || v.align)
                    check($sformatf("period %0d length byte %02h", p, v.data), cyc + 1, 8);
                p++;
                cyc = 0;
            end else begin
                cyc++;
            end
            @(negedge clk_in);
        end
        check("frame reached end", p, 12);
        tx_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, align: 1'b0, busy: 1'b0, par_even: 1'b0, par_odd: 1'b1};
        vecs[1] = '{data: 8'h01, align: 1'b0, busy: 1'b0, par_even: 1'b1, par_odd: 1'b0};
        vecs[2] = '{data: 8'hFF, align: 1'b0, busy: 1'b0, par_even: 1'b0, par_odd: 1'b1};
        vecs[3] = '{data: 8'h80, align: 1'b1, busy: 1'b0, par_even: 1'b1, par_odd: 1'b0};
        vecs[4] = '{data: 8'h6E, align: 1'b0, busy: 1'b1, par_even: 1'b1, par_odd: 1'b0};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk_in);
        check("reset tx", tx_v, 4'hF);
        check("reset tx_done", done_v, 4'h0);
        rst = 1'b0;
        @(negedge clk_in);
        check("ready after reset", ready_v, 4'hF);
        check("idle tx after reset", tx_v, 4'hF);
        check("no done after reset", done_v, 4'h0);

        foreach (vecs[k]) run_frame(vecs[k]);

        // Back-to-back: second byte presented in the base tx_done cycle.
        wait_all_ready();
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        begin
            int g = 0;
            while (done_v[0] !== 1'b1 && g < 200) begin
                @(negedge clk_in);
                g++;
            end
            check("b2b first tx_done seen", done_v[0], 1'b1);
        end
        check("b2b ready on done cycle", ready_v[0], 1'b1);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        check("b2b second byte accepted", ready_v[0], 1'b0);
        begin
            int g = 0;
            while (!tick_next() && g < 40) begin
                check("b2b tx high before start", tx_v[0], 1'b1);
                @(negedge clk_in);
                g++;
            end
            check("b2b tx high at tick cycle", tx_v[0], 1'b1);
        end
        @(negedge clk_in);
        check("b2b start bit on next tick", tx_v[0], 1'b0);
        wait_tick();
        check("b2b data bit 0", tx_v[0], 1'b0);
        wait_tick();
        check("b2b data bit 1", tx_v[0], 1'b0);
        wait_tick();
        check("b2b data bit 2", tx_v[0], 1'b1);

        // Mid-frame reset during data bit 3.
        wait_all_ready();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        repeat (5) wait_tick();
        check("bit 3 before reset", tx_v, 4'h0);
        rst = 1'b1;
        @(negedge clk_in);
        check("tx high after mid-frame reset", tx_v, 4'hF);
        check("no done in reset", done_v, 4'h0);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        check("ready after mid-frame reset", ready_v, 4'hF);
        begin
            logic [3:0] seen = 4'h0;
            for (int n = 0; n < 120; n++) begin
                seen |= done_v | ~tx_v;
                @(negedge clk_in);
            end
            check("no done and idle line after abort", seen, 4'h0);
        end
        run_frame('{data: 8'h3C, align: 1'b0, busy: 1'b0, par_even: 1'b0, par_odd: 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
